// File: rtl/arena_ctrl.sv
// arena_ctrl: N-player round-based combat controller (round timer, action latch, damage resolution, win detection).
// Optional build macro ARENA_AUTO_LOCK_EN: a round resolves early once every alive player has latched an action.
module arena_ctrl #(
    parameter int NUM_PLAYERS   = 2,
    parameter int HP_W          = 2,
    parameter int ENG_W         = 2,
    parameter int ROUND_SECS    = 5,
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [3*NUM_PLAYERS-1:0]      act_p,
    output logic [2:0]                    state,
    output logic [3:0]                    cnt_time,
    output logic [HP_W*NUM_PLAYERS-1:0]   hp,
    output logic [ENG_W*NUM_PLAYERS-1:0]  eng,
    output logic [3*NUM_PLAYERS-1:0]      sel,
    output logic                          game_over,
    output logic [1:0]                    winner,
    output logic                          winner_valid
);

    // start and act_p are single-cycle pulses with no back-pressure: a pulse is
    // consumed on the edge that samples it, or dropped if the state ignores it.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ROUND   = 3'd1,
        S_RESOLVE = 3'd2,
        S_CHECK   = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    localparam int             PW       = $clog2(TICKS_PER_SEC);
    localparam logic [2:0]     SEL_CHG  = 3'b001;
    localparam logic [2:0]     SEL_ATK  = 3'b010;
    localparam logic [2:0]     SEL_DEF  = 3'b100;
    localparam logic [HP_W-1:0]  HP_FULL = {HP_W{1'b1}};
    localparam logic [ENG_W-1:0] ENG_MAX = {ENG_W{1'b1}};
    localparam logic [3:0]     SECS     = 4'(ROUND_SECS);

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q;
    logic [HP_W-1:0]  hp_q    [NUM_PLAYERS];
    logic [ENG_W-1:0] eng_q   [NUM_PLAYERS];
    logic [2:0]       sel_q   [NUM_PLAYERS];
    logic [HP_W-1:0]  hp_res  [NUM_PLAYERS];
    logic [ENG_W-1:0] eng_res [NUM_PLAYERS];
    logic [2:0]       sel_nxt [NUM_PLAYERS];
    logic             tick;
    logic             lock;
    logic [1:0]       alive_idx;
    int               alive;
    int               n_atk;
    int               hits;

    assign tick      = (presc_q == PW'(TICKS_PER_SEC - 1));
    assign state     = state_q;
    assign game_over = (state_q == S_OVER);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign hp[g*HP_W +: HP_W]   = hp_q[g];
        assign eng[g*ENG_W +: ENG_W] = eng_q[g];
        assign sel[g*3 +: 3]        = sel_q[g];
    end

    // Action latch, alive census and round resolution, all from registered values.
    always_comb begin
        alive     = 0;
        alive_idx = 2'd0;
        n_atk     = 0;
        hits      = 0;
        lock      = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            sel_nxt[p] = sel_q[p];
            hp_res[p]  = hp_q[p];
            eng_res[p] = eng_q[p];
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (hp_q[p] != '0) begin
                alive     = alive + 1;
                alive_idx = 2'(p);
            end
            if (sel_q[p] == 3'b000 && hp_q[p] != '0) begin
                if (act_p[3*p+2])      sel_nxt[p] = SEL_DEF;
                else if (act_p[3*p+1]) sel_nxt[p] = SEL_ATK;
                else if (act_p[3*p])   sel_nxt[p] = SEL_CHG;
            end
            if (sel_q[p] == SEL_ATK && eng_q[p] != '0) n_atk = n_atk + 1;
        end
        for (int q = 0; q < NUM_PLAYERS; q++) begin
            // An attacker never damages itself.
            hits = n_atk - ((sel_q[q] == SEL_ATK && eng_q[q] != '0) ? 1 : 0);
            if (hp_q[q] != '0 && sel_q[q] != SEL_DEF)
                hp_res[q] = (int'(hp_q[q]) > hits) ? hp_q[q] - HP_W'(hits) : '0;
            if (sel_q[q] == SEL_CHG && eng_q[q] != ENG_MAX)
                eng_res[q] = eng_q[q] + ENG_W'(1);
            else if (sel_q[q] == SEL_ATK && eng_q[q] != '0)
                eng_res[q] = eng_q[q] - ENG_W'(1);
        end
`ifdef ARENA_AUTO_LOCK_EN
        lock = 1'b1;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (hp_q[p] != '0 && sel_q[p] == 3'b000) lock = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (start) state_d = S_ROUND;
            S_ROUND:        if (lock || (tick && cnt_time == 4'd1)) state_d = S_RESOLVE;
            S_RESOLVE:      state_d = S_CHECK;
            S_CHECK:        state_d = (alive >= 2) ? S_ROUND : S_OVER;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            cnt_time     <= 4'd0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                hp_q[p]  <= '0;
                eng_q[p] <= '0;
                sel_q[p] <= 3'b000;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        presc_q      <= '0;
                        cnt_time     <= SECS;
                        winner       <= 2'd0;
                        winner_valid <= 1'b0;
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            hp_q[p]  <= HP_FULL;
                            eng_q[p] <= '0;
                            sel_q[p] <= 3'b000;
                        end
                    end
                end
                S_ROUND: begin
                    for (int p = 0; p < NUM_PLAYERS; p++) sel_q[p] <= sel_nxt[p];
                    // An early lock freezes the timer at its current value.
                    if (!lock) begin
                        if (tick) begin
                            presc_q  <= '0;
                            cnt_time <= cnt_time - 4'd1;
                        end else begin
                            presc_q  <= presc_q + PW'(1);
                        end
                    end
                end
                S_RESOLVE: begin
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        hp_q[p]  <= hp_res[p];
                        eng_q[p] <= eng_res[p];
                    end
                end
                S_CHECK: begin
                    if (alive >= 2) begin
                        presc_q  <= '0;
                        cnt_time <= SECS;
                        for (int p = 0; p < NUM_PLAYERS; p++) sel_q[p] <= 3'b000;
                    end else begin
                        winner       <= (alive == 1) ? alive_idx : 2'd0;
                        winner_valid <= (alive == 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arena_ctrl.sv
// Self-checking bench for arena_ctrl: directed and random rounds against a round-level behavioural model.
// Honours ARENA_AUTO_LOCK_EN when the design is built with it.
`timescale 1ns/1ps
module tb_arena_ctrl;
    localparam int NP   = 2;
    localparam int HW   = 2;
    localparam int EW   = 2;
    localparam int RS   = 3;
    localparam int TPS  = 4;
    localparam int RL   = RS * TPS;
    localparam int AW   = 3 * NP;
    localparam int HMAX = 3;
    localparam int EMAX = 3;
    localparam logic [2:0] CHG = 3'b001;
    localparam logic [2:0] ATK = 3'b010;
    localparam logic [2:0] DEF = 3'b100;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  act_p = '0;
    logic [2:0]     state;
    logic [3:0]     cnt_time;
    logic [HW*NP-1:0] hp;
    logic [EW*NP-1:0] eng;
    logic [AW-1:0]  sel;
    logic           game_over;
    logic [1:0]     winner;
    logic           winner_valid;

    int checks = 0;
    int errors = 0;
    int m_hp [NP];
    int m_eng[NP];
    int m_sel[NP];
    logic [AW-1:0] stim [RL];

    always #5 clock = ~clock;

    arena_ctrl #(
        .NUM_PLAYERS(NP), .HP_W(HW), .ENG_W(EW), .ROUND_SECS(RS), .TICKS_PER_SEC(TPS)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .act_p(act_p),
        .state(state), .cnt_time(cnt_time), .hp(hp), .eng(eng), .sel(sel),
        .game_over(game_over), .winner(winner), .winner_valid(winner_valid)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [HW*NP-1:0] exp_hp();
        logic [HW*NP-1:0] r;
        for (int p = 0; p < NP; p++) r[p*HW +: HW] = HW'(m_hp[p]);
        return r;
    endfunction

    function automatic logic [EW*NP-1:0] exp_eng();
        logic [EW*NP-1:0] r;
        for (int p = 0; p < NP; p++) r[p*EW +: EW] = EW'(m_eng[p]);
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_sel();
        logic [AW-1:0] r;
        for (int p = 0; p < NP; p++) r[p*3 +: 3] = 3'(m_sel[p]);
        return r;
    endfunction

    function automatic int m_alive();
        int n = 0;
        for (int p = 0; p < NP; p++) if (m_hp[p] > 0) n++;
        return n;
    endfunction

    function automatic int m_last_alive();
        int w = 0;
        for (int p = 0; p < NP; p++) if (m_hp[p] > 0) w = p;
        return w;
    endfunction

    function automatic bit m_locked();
`ifdef ARENA_AUTO_LOCK_EN
        bit r = 1'b1;
        for (int p = 0; p < NP; p++) if (m_hp[p] > 0 && m_sel[p] == 0) r = 1'b0;
        return r;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_latch(input logic [AW-1:0] a);
        int s;
        for (int p = 0; p < NP; p++) begin
            s = (int'(a) >> (3*p)) & 7;
            if (m_sel[p] == 0 && m_hp[p] > 0 && s != 0)
                m_sel[p] = (s >= 4) ? 4 : (s >= 2) ? 2 : 1;
        end
    endtask

    task automatic m_resolve();
        int attackers = 0;
        bit armed [NP];
        for (int p = 0; p < NP; p++) begin
            armed[p] = (m_sel[p] == 2 && m_eng[p] >= 1);
            if (armed[p]) attackers++;
        end
        for (int q = 0; q < NP; q++) begin
            if (m_hp[q] > 0 && m_sel[q] != 4) begin
                m_hp[q] = m_hp[q] - (attackers - (armed[q] ? 1 : 0));
                if (m_hp[q] < 0) m_hp[q] = 0;
            end
            if (m_sel[q] == 1 && m_eng[q] < EMAX) m_eng[q]++;
            if (armed[q]) m_eng[q]--;
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic do_start();
        start = 1'b1;
        act_p = AW'($urandom);
        step();
        start = 1'b0;
        act_p = '0;
        for (int p = 0; p < NP; p++) begin
            m_hp[p] = HMAX; m_eng[p] = 0; m_sel[p] = 0;
        end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_state got %0d want 1", state); end
        checks++; if (cnt_time !== 4'(RS)) begin errors++; $display("FAIL start_cnt got %0d want %0d", cnt_time, RS); end
        checks++; if (hp !== exp_hp()) begin errors++; $display("FAIL start_hp got %h want %h", hp, exp_hp()); end
        checks++; if (eng !== exp_eng()) begin errors++; $display("FAIL start_eng got %h want %h", eng, exp_eng()); end
        checks++; if (sel !== '0) begin errors++; $display("FAIL start_sel got %h want 0", sel); end
        checks++; if (game_over !== 1'b0 || winner_valid !== 1'b0) begin
            errors++; $display("FAIL start_flags got go=%b wv=%b want 0 0", game_over, winner_valid);
        end
    endtask

    // Plays one round from ROUND entry using stim[], through RESOLVE and CHECK.
    task automatic run_round(input bit rnd_start);
        int n = 0;
        bit done = 1'b0;
        bit lk;
        logic [3:0] exp_cnt = 4'(RS);
        int alive;
        for (int k = 0; k < RL && !done; k++) begin
            lk = m_locked();
            act_p = stim[k];
            start = rnd_start && ($urandom_range(0, 5) == 0);
            m_latch(stim[k]);
            step();
            act_p = '0;
            start = 1'b0;
            if (lk) done = 1'b1;
            else begin
                n++;
                exp_cnt = 4'(RS - n / TPS);
                done = (n == RL);
            end
            checks++; if (state !== (done ? 3'd2 : 3'd1)) begin
                errors++; $display("FAIL round_state cyc %0d got %0d want %0d", k, state, done ? 2 : 1);
            end
            checks++; if (cnt_time !== exp_cnt) begin
                errors++; $display("FAIL round_cnt cyc %0d got %0d want %0d", k, cnt_time, exp_cnt);
            end
            checks++; if (sel !== exp_sel()) begin
                errors++; $display("FAIL round_sel cyc %0d got %h want %h", k, sel, exp_sel());
            end
        end
        act_p = AW'($urandom);
        start = ($urandom_range(0, 1) == 0);
        step();
        act_p = '0;
        start = 1'b0;
        m_resolve();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL check_state got %0d want 3", state); end
        checks++; if (hp !== exp_hp()) begin errors++; $display("FAIL resolve_hp got %h want %h", hp, exp_hp()); end
        checks++; if (eng !== exp_eng()) begin errors++; $display("FAIL resolve_eng got %h want %h", eng, exp_eng()); end
        act_p = AW'($urandom);
        step();
        act_p = '0;
        alive = m_alive();
        if (alive >= 2) begin
            for (int p = 0; p < NP; p++) m_sel[p] = 0;
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL next_state got %0d want 1", state); end
            checks++; if (cnt_time !== 4'(RS)) begin errors++; $display("FAIL next_cnt got %0d want %0d", cnt_time, RS); end
            checks++; if (sel !== '0) begin errors++; $display("FAIL next_sel got %h want 0", sel); end
            checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL next_go got %b want 0", game_over); end
        end else begin
            checks++; if (state !== 3'd4) begin errors++; $display("FAIL over_state got %0d want 4", state); end
            checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_go got %b want 1", game_over); end
            checks++; if (winner_valid !== (alive == 1)) begin
                errors++; $display("FAIL over_wv got %b want %b", winner_valid, alive == 1);
            end
            checks++; if (winner !== ((alive == 1) ? 2'(m_last_alive()) : 2'd0)) begin
                errors++; $display("FAIL over_winner got %0d want %0d", winner, (alive == 1) ? m_last_alive() : 0);
            end
            checks++; if (sel !== exp_sel()) begin errors++; $display("FAIL over_sel got %h want %h", sel, exp_sel()); end
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < RL; k++) stim[k] = '0;
    endtask

    task automatic do_round(input logic [2:0] a0, input logic [2:0] a1);
        int c;
        clear_stim();
        c = $urandom_range(0, 3);
        stim[c][2:0] = a0;
        c = $urandom_range(0, 3);
        stim[c][5:3] = a1;
        run_round(1'b1);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        checks++; if (state !== 3'd0 || cnt_time !== 4'd0) begin
            errors++; $display("FAIL reset_state got st=%0d cnt=%0d want 0 0", state, cnt_time);
        end
        checks++; if (hp !== '0 || eng !== '0 || sel !== '0) begin
            errors++; $display("FAIL reset_regs got hp=%h eng=%h sel=%h want 0", hp, eng, sel);
        end
        checks++; if (game_over !== 1'b0 || winner !== 2'd0 || winner_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags got go=%b w=%0d wv=%b want 0", game_over, winner, winner_valid);
        end
        act_p = AW'($urandom);
        repeat (3) step();
        act_p = '0;
        checks++; if (state !== 3'd0 || sel !== '0) begin
            errors++; $display("FAIL idle_hold got st=%0d sel=%h want 0 0", state, sel);
        end
    endtask

    task automatic test_idle_round();
        clear_stim();
        run_round(1'b0);
    endtask

    task automatic test_charge_attack();
        do_round(CHG, DEF);
        do_round(ATK, 3'b000);
    endtask

    task automatic test_attack_no_energy();
        do_round(ATK, 3'b000);
        do_round(CHG, 3'b000);
        do_round(ATK, DEF);
    endtask

    task automatic test_priority();
        clear_stim();
        stim[1][2:0] = 3'b110;
        stim[4][2:0] = 3'b001;
        stim[6][2:0] = 3'b010;
        run_round(1'b0);
    endtask

    task automatic test_lock();
        clear_stim();
        stim[5] = {CHG, CHG};
        run_round(1'b0);
    endtask

    task automatic test_win();
        for (int i = 0; i < 8 && m_alive() >= 2; i++) begin
            do_round(CHG, 3'b000);
            if (m_alive() >= 2) do_round(ATK, 3'b000);
        end
        for (int i = 0; i < 4; i++) begin
            act_p = AW'($urandom);
            step();
            act_p = '0;
            checks++; if (state !== 3'd4 || hp !== exp_hp() || eng !== exp_eng() || sel !== exp_sel()) begin
                errors++; $display("FAIL over_hold got st=%0d hp=%h eng=%h sel=%h want 4 %h %h %h",
                                   state, hp, eng, sel, exp_hp(), exp_eng(), exp_sel());
            end
        end
        do_start();
    endtask

    task automatic test_draw();
        for (int i = 0; i < 8 && m_alive() >= 2; i++) begin
            do_round(CHG, CHG);
            if (m_alive() >= 2) do_round(ATK, ATK);
        end
        do_start();
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            if (m_alive() < 2) do_start();
            for (int k = 0; k < RL; k++)
                stim[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : '0;
            run_round(1'b1);
        end
    endtask

    task automatic test_reset_mid();
        if (m_alive() < 2) do_start();
        stim[0] = '0;
        repeat (5) step();
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || cnt_time !== 4'd0 || hp !== '0 || eng !== '0 || sel !== '0) begin
            errors++; $display("FAIL midreset_regs got st=%0d cnt=%0d hp=%h eng=%h sel=%h want 0",
                               state, cnt_time, hp, eng, sel);
        end
        checks++; if (game_over !== 1'b0 || winner !== 2'd0 || winner_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_flags got go=%b w=%0d wv=%b want 0", game_over, winner, winner_valid);
        end
        step();
        resetn = 1'b1;
        step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL midreset_idle got %0d want 0", state); end
        do_start();
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            m_hp[p] = 0; m_eng[p] = 0; m_sel[p] = 0;
        end
        test_reset();
        do_start();
        test_idle_round();
        test_charge_attack();
        test_attack_no_energy();
        test_priority();
        test_lock();
        test_win();
        test_draw();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
